// File: rtl/sfr_bus_pkg.sv
// Shared widths and FSM state type for the SFR bus master/arbiter.
package sfr_bus_pkg;
  localparam int SFR_AW  = 16;
  localparam int SFR_DW  = 8;
  localparam int MAX_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_DONE   = 2'd3
  } bus_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after i_ptr wins.
module rr_arbiter
  import sfr_bus_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);
  localparam int SW = IDX_W + 1;

  logic [MAX_REQ-1:0] w_req_ext;
  logic [SW-1:0]      w_sum;
  logic [IDX_W-1:0]   w_cand;

  assign w_req_ext = MAX_REQ'(i_req);

  // Walk offsets from farthest to nearest so the nearest hit is the last one written.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_sum = {1'b0, i_ptr} + SW'(off);
      if (w_sum >= SW'(NUM_REQ)) w_sum = w_sum - SW'(NUM_REQ);
      w_cand = w_sum[IDX_W-1:0];
      if (w_req_ext[w_cand]) begin
        o_idx   = w_cand;
        o_valid = 1'b1;
      end
    end
  end

  assign o_gnt = o_valid ? NUM_REQ'(MAX_REQ'(1) << o_idx) : '0;
endmodule

// File: rtl/sfr_bus_arbiter.sv
// SFR bus master: round-robin among NUM_REQ requesters, fixed 4-cycle access.
// States: S_IDLE arbitrate+latch | S_SETUP address out | S_STROBE set/enable pulse | S_DONE done pulse
module sfr_bus_arbiter
  import sfr_bus_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_we,
  input  logic [SFR_AW*NUM_REQ-1:0] i_addr,
  input  logic [SFR_DW*NUM_REQ-1:0] i_wdata,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [NUM_REQ-1:0]        o_done,
  output logic [SFR_DW-1:0]         o_rdata,
  output logic [SFR_AW-1:0]         o_address,
  output logic                      o_ad_set,
  output logic                      o_ad_enable,
  inout  wire  [SFR_DW-1:0]         io_ad_data
);
  bus_state_t         r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic               r_we;
  logic               r_drv;
  logic [SFR_DW-1:0]  r_wdata;

  logic [IDX_W-1:0]   w_idx;
  logic               w_valid;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_we;
  logic [SFR_AW-1:0]  w_addr;
  logic [SFR_DW-1:0]  w_wdata;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_idx == IDX_W'(k)) begin
        w_we    = i_we[k];
        w_addr  = i_addr[k*SFR_AW +: SFR_AW];
        w_wdata = i_wdata[k*SFR_DW +: SFR_DW];
      end
    end
  end

  // Only the registered write-strobe flag enables the driver, so the bus is Z in reset.
  assign io_ad_data = r_drv ? r_wdata : 'z;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_we        <= 1'b0;
      r_drv       <= 1'b0;
      r_wdata     <= '0;
      o_gnt       <= '0;
      o_done      <= '0;
      o_rdata     <= '0;
      o_address   <= '0;
      o_ad_set    <= 1'b0;
      o_ad_enable <= 1'b0;
    end else begin
      o_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_state   <= S_SETUP;
            r_idx     <= w_idx;
            r_we      <= w_we;
            r_wdata   <= w_wdata;
            o_address <= w_addr;
            o_gnt     <= w_gnt;
          end
        end
        S_SETUP: begin
          r_state     <= S_STROBE;
          o_ad_set    <= r_we;
          o_ad_enable <= ~r_we;
          r_drv       <= r_we;
        end
        S_STROBE: begin
          r_state     <= S_DONE;
          o_ad_set    <= 1'b0;
          o_ad_enable <= 1'b0;
          r_drv       <= 1'b0;
          o_done      <= o_gnt;
          if (!r_we) o_rdata <= io_ad_data;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          o_gnt   <= '0;
          r_ptr   <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
